// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with ALU decode and operand-B select; define ID_EX_FORWARD_EN for EX/MEM and MEM/WB bypass
module id_ex_stage #(
    parameter int XLEN = 64
) (
    input  logic            clk,
`ifdef ID_EX_FORWARD_EN
    input  logic            exmem_reg_write,
    input  logic [4:0]      exmem_rd,
    input  logic [XLEN-1:0] exmem_result,
    input  logic            memwb_reg_write,
    input  logic [4:0]      memwb_rd,
    input  logic [XLEN-1:0] memwb_result,
`endif
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic            in_valid,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    input  logic [4:0]      rd,
    input  logic            alu_src,
    input  logic [1:0]      alu_op,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic            reg_write,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic            mem_to_reg,
    input  logic            branch,
    output logic            ex_valid,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [XLEN-1:0] ex_store_data,
    output logic [3:0]      alu_control_signal,
    output logic [4:0]      ex_rd,
    output logic            illegal_op,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_mem_to_reg,
    output logic            ex_branch
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;
    state_t state, state_nxt;
    logic [XLEN-1:0] rs1_val, rs2_val;
    logic [3:0] ctrl;
    logic ill;
`ifdef ID_EX_FORWARD_EN
    logic fa_ex, fa_wb, fb_ex, fb_wb;
    assign fa_ex = exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == rs1;
    assign fa_wb = memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == rs1;
    assign fb_ex = exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == rs2;
    assign fb_wb = memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == rs2;
    assign rs1_val = fa_ex ? exmem_result : fa_wb ? memwb_result : rs1_data;
    assign rs2_val = fb_ex ? exmem_result : fb_wb ? memwb_result : rs2_data;
`else
    logic unused_idx;
    assign unused_idx = ^{rs1, rs2};
    assign rs1_val = rs1_data;
    assign rs2_val = rs2_data;
`endif
    // I-type ignores funct7_5 on funct3 000 since addi has no subtract form
    always_comb begin
        ctrl = alu_op == 2'b00 ? 4'b0010 :
               alu_op == 2'b01 ? 4'b0110 :
               funct3 == 3'b000 ? ((alu_op[0] || !funct7_5) ? 4'b0010 : 4'b0110) :
               funct3 == 3'b100 ? 4'b0100 :
               funct3 == 3'b110 ? 4'b0001 :
               funct3 == 3'b111 ? 4'b0000 : 4'b1111;
        ill = ctrl == 4'b1111;
    end
    always_comb begin
        state_nxt = state;
        if (rst || flush)
            state_nxt = EMPTY;
        else if (!stall)
            state_nxt = in_valid ? FULL : EMPTY;
    end
    always_ff @(posedge clk) state <= rst ? EMPTY : state_nxt;
    assign ex_valid = state;
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            alu_a              <= '0;
            alu_b              <= '0;
            ex_store_data      <= '0;
            alu_control_signal <= '0;
            ex_rd              <= '0;
            illegal_op         <= 1'b0;
            ex_reg_write       <= 1'b0;
            ex_mem_read        <= 1'b0;
            ex_mem_write       <= 1'b0;
            ex_mem_to_reg      <= 1'b0;
            ex_branch          <= 1'b0;
        end else if (!stall) begin
            alu_a              <= rs1_val;
            alu_b              <= alu_src ? imm : rs2_val;
            ex_store_data      <= rs2_val;
            alu_control_signal <= ctrl;
            ex_rd              <= rd;
            illegal_op         <= in_valid && ill;
            ex_reg_write       <= in_valid && reg_write;
            ex_mem_read        <= in_valid && mem_read;
            ex_mem_write       <= in_valid && mem_write;
            ex_mem_to_reg      <= mem_to_reg;
            ex_branch          <= in_valid && branch;
        end
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed checks of decode, operand select, stall/flush/reset and optional forwarding
module tb_id_ex_stage;
    logic clk = 0;
    logic rst, stall, flush, in_valid, alu_src, funct7_5;
    logic reg_write, mem_read, mem_write, mem_to_reg, branch;
    logic [63:0] rs1_data, rs2_data, imm;
    logic [4:0] rs1, rs2, rd;
    logic [1:0] alu_op;
    logic [2:0] funct3;
    logic ex_valid, illegal_op, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch;
    logic [63:0] alu_a, alu_b, ex_store_data;
    logic [3:0] alu_control_signal;
    logic [4:0] ex_rd;
`ifdef ID_EX_FORWARD_EN
    logic exmem_reg_write, memwb_reg_write;
    logic [4:0] exmem_rd, memwb_rd;
    logic [63:0] exmem_result, memwb_result;
`endif
    int errors = 0;
    int checks = 0;

    id_ex_stage dut (
        .clk(clk),
`ifdef ID_EX_FORWARD_EN
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
`endif
        .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
        .rs1(rs1), .rs2(rs2), .rd(rd), .alu_src(alu_src), .alu_op(alu_op),
        .funct3(funct3), .funct7_5(funct7_5), .reg_write(reg_write), .mem_read(mem_read),
        .mem_write(mem_write), .mem_to_reg(mem_to_reg), .branch(branch),
        .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b), .ex_store_data(ex_store_data),
        .alu_control_signal(alu_control_signal), .ex_rd(ex_rd), .illegal_op(illegal_op),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".valid"}, {63'd0, ex_valid}, 64'd0);
        chk({tag, ".a"}, alu_a, 64'd0);
        chk({tag, ".b"}, alu_b, 64'd0);
        chk({tag, ".sd"}, ex_store_data, 64'd0);
        chk({tag, ".ctrl"}, {60'd0, alu_control_signal}, 64'd0);
        chk({tag, ".rd"}, {59'd0, ex_rd}, 64'd0);
        chk({tag, ".flags"}, {57'd0, illegal_op, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch, 1'b0}, 64'd0);
    endtask

    typedef struct {logic [1:0] op; logic [2:0] f3; logic f7; logic [3:0] ctrl; logic ill;} dec_t;
    dec_t dec_tab[9];

    initial begin
        dec_tab[0] = '{2'b10, 3'b000, 1'b1, 4'b0110, 1'b0};
        dec_tab[1] = '{2'b10, 3'b100, 1'b0, 4'b0100, 1'b0};
        dec_tab[2] = '{2'b10, 3'b110, 1'b0, 4'b0001, 1'b0};
        dec_tab[3] = '{2'b10, 3'b111, 1'b0, 4'b0000, 1'b0};
        dec_tab[4] = '{2'b11, 3'b000, 1'b1, 4'b0010, 1'b0};
        dec_tab[5] = '{2'b10, 3'b001, 1'b0, 4'b1111, 1'b1};
        dec_tab[6] = '{2'b00, 3'b111, 1'b1, 4'b0010, 1'b0};
        dec_tab[7] = '{2'b01, 3'b001, 1'b0, 4'b0110, 1'b0};
        dec_tab[8] = '{2'b11, 3'b101, 1'b0, 4'b1111, 1'b1};
`ifdef ID_EX_FORWARD_EN
        exmem_reg_write = 0; memwb_reg_write = 0; exmem_rd = 0; memwb_rd = 0;
        exmem_result = 0; memwb_result = 0;
`endif
        rst = 1; stall = $urandom_range(1); flush = $urandom_range(1); in_valid = 1;
        rs1_data = {$urandom, $urandom}; rs2_data = {$urandom, $urandom}; imm = {$urandom, $urandom};
        rs1 = 5'($urandom); rs2 = 5'($urandom); rd = 5'($urandom); alu_src = $urandom_range(1);
        alu_op = 2'($urandom); funct3 = 3'($urandom); funct7_5 = $urandom_range(1);
        reg_write = 1; mem_read = 1; mem_write = 1; mem_to_reg = 1; branch = 1;
        step();
        step();
        chk_zero("reset");
        rst = 0; stall = 0; flush = 0;
        rs1 = 1; rs2 = 2; rd = 3; rs1_data = 5; rs2_data = 7; alu_src = 0;
        alu_op = 2'b10; funct3 = 0; funct7_5 = 0;
        mem_read = 0; mem_write = 0; mem_to_reg = 0; branch = 0;
        step();
        chk("add.a", alu_a, 64'd5);
        chk("add.b", alu_b, 64'd7);
        chk("add.ctrl", {60'd0, alu_control_signal}, 64'b0010);
        chk("add.valid", {63'd0, ex_valid}, 64'd1);
        chk("add.rw", {63'd0, ex_reg_write}, 64'd1);
        chk("add.rd", {59'd0, ex_rd}, 64'd3);
        foreach (dec_tab[i]) begin
            alu_op = dec_tab[i].op; funct3 = dec_tab[i].f3; funct7_5 = dec_tab[i].f7;
            step();
            chk($sformatf("dec%0d.ctrl", i), {60'd0, alu_control_signal}, {60'd0, dec_tab[i].ctrl});
            chk($sformatf("dec%0d.ill", i), {63'd0, illegal_op}, {63'd0, dec_tab[i].ill});
        end
        alu_op = 2'b00; funct3 = 3'b011; alu_src = 1; imm = 64'hFFFF_FFFF_FFFF_FFF0; rs2_data = 3;
        mem_write = 1; reg_write = 0;
        step();
        chk("imm.b", alu_b, 64'hFFFF_FFFF_FFFF_FFF0);
        chk("imm.sd", ex_store_data, 64'd3);
        chk("imm.mw", {63'd0, ex_mem_write}, 64'd1);
        chk("imm.rw", {63'd0, ex_reg_write}, 64'd0);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            rs1_data = 64'(100 + i); rs2_data = 64'(200 + i); imm = 64'(i); alu_src = 0;
            alu_op = 2'b10; funct3 = 3'b100; rd = 5'(9 + i); in_valid = 0; mem_write = 0;
            step();
            chk($sformatf("stall%0d.a", i), alu_a, 64'd5);
            chk($sformatf("stall%0d.b", i), alu_b, 64'hFFFF_FFFF_FFFF_FFF0);
            chk($sformatf("stall%0d.ctrl", i), {60'd0, alu_control_signal}, 64'b0010);
            chk($sformatf("stall%0d.valid", i), {63'd0, ex_valid}, 64'd1);
            chk($sformatf("stall%0d.rd", i), {59'd0, ex_rd}, 64'd3);
        end
        flush = 1; in_valid = 1; reg_write = 1;
        step();
        chk_zero("flush");
        flush = 0; stall = 0; in_valid = 0; reg_write = 1; mem_write = 1; branch = 1; mem_read = 1;
        alu_op = 2'b10; funct3 = 3'b001; rs1_data = 64'h1234; rd = 7;
        step();
        chk("inv.valid", {63'd0, ex_valid}, 64'd0);
        chk("inv.rw", {63'd0, ex_reg_write}, 64'd0);
        chk("inv.mw", {63'd0, ex_mem_write}, 64'd0);
        chk("inv.mr_br", {62'd0, ex_mem_read, ex_branch}, 64'd0);
        chk("inv.ill", {63'd0, illegal_op}, 64'd0);
        chk("inv.a", alu_a, 64'h1234);
        chk("inv.rd", {59'd0, ex_rd}, 64'd7);
        in_valid = 1; funct3 = 3'b110; mem_write = 0; mem_read = 0; branch = 0;
        step();
        chk("reload.valid", {63'd0, ex_valid}, 64'd1);
        chk("reload.ctrl", {60'd0, alu_control_signal}, 64'b0001);
        stall = 1; rst = 1;
        step();
        chk_zero("rst_stall");
        rst = 0;
        step();
        chk_zero("rst_stall_hold");
        stall = 0;
`ifdef ID_EX_FORWARD_EN
        rs1 = 4; rs1_data = 64'h11; alu_op = 2'b10; funct3 = 0; funct7_5 = 0;
        exmem_reg_write = 1; exmem_rd = 4; exmem_result = 64'hAA;
        memwb_reg_write = 1; memwb_rd = 4; memwb_result = 64'hBB;
        step();
        chk("fwd.exmem", alu_a, 64'hAA);
        exmem_reg_write = 0;
        step();
        chk("fwd.memwb", alu_a, 64'hBB);
        rs2 = 4; rs2_data = 64'h22; alu_src = 0;
        step();
        chk("fwd.b", alu_b, 64'hBB);
        chk("fwd.sd", ex_store_data, 64'hBB);
        rs1 = 0; exmem_reg_write = 1; exmem_rd = 0; memwb_rd = 0;
        step();
        chk("fwd.x0", alu_a, 64'h11);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
